// File: rtl/act_fetch_server_pkg.sv
// -----------------------------------------------------------------------------
// act_fetch_server_pkg
// Shared definitions for the activation fetch responder:
//   - default widths, kept in step with the loop-controller width macros
//   - SRAM read latency used by the activation SRAM wrapper
//   - 2-bit FSM state encoding
// -----------------------------------------------------------------------------
package act_fetch_server_pkg;

   localparam int ACT_WIDTH_DEF  = 64;   // activation word width
   localparam int ADDR_WIDTH_DEF = 12;   // word address width per bank
   localparam int SRAM_LAT_DEF   = 2;    // fixed SRAM read latency (1..4)
   localparam int PEND_WIDTH_DEF = 3;    // pending-request counter width

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BANK = 2'd1,
      ST_SERVE     = 2'd2,
      ST_DRAIN     = 2'd3
   } state_e;

endpackage

// File: rtl/act_fetch_server_rd_pipe.sv
// -----------------------------------------------------------------------------
// act_rd_pipe
// Tracks reads in flight to the activation SRAM and captures returned words.
//   clk, rst_n      : clock, asynchronous active-low reset
//   rd_issue        : a read is presented to the SRAM this cycle
//   rd_data         : SRAM read data
//   act_data        : captured activation word, held until the next get_act
//   get_act         : one-cycle strobe, act_data valid
//   inflight_empty  : no read is in flight
//
// A read issued in cycle r shows up as get_act in cycle r+SRAM_LAT. The SRAM
// word is sampled on the same edge that raises get_act, so the data register
// and the strobe always line up.
// -----------------------------------------------------------------------------
module act_rd_pipe
   import act_fetch_server_pkg::*;
#(
   parameter int ACT_WIDTH = ACT_WIDTH_DEF,
   parameter int SRAM_LAT  = SRAM_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rd_issue,
   input  logic [ACT_WIDTH-1:0] rd_data,
   output logic [ACT_WIDTH-1:0] act_data,
   output logic                 get_act,
   output logic                 inflight_empty
);

   logic [SRAM_LAT-1:0]  vld_q;
   logic [SRAM_LAT-1:0]  vld_d;
   logic [ACT_WIDTH-1:0] data_q;
   logic [ACT_WIDTH-1:0] data_d;
   logic                 cap_en;

   // The capture enable is the stage just before the last one, so the data
   // register loads on the edge where the last stage becomes valid.
   generate
      if (SRAM_LAT == 1) begin : g_lat1
         assign vld_d  = rd_issue;
         assign cap_en = rd_issue;
      end else begin : g_latn
         assign vld_d  = {vld_q[SRAM_LAT-2:0], rd_issue};
         assign cap_en = vld_q[SRAM_LAT-2];
      end
   endgenerate

   always_comb begin
      data_d = data_q;
      if (cap_en) begin
         data_d = rd_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign get_act        = vld_q[SRAM_LAT-1];
   assign act_data       = data_q;
   assign inflight_empty = ~|vld_q;

endmodule

// File: rtl/act_fetch_server.sv
// -----------------------------------------------------------------------------
// act_fetch_server
// Responder side of the activation fetch handshake. Each fetch_req pulse
// requests one word from the ping-pong activation SRAM; each word comes back
// with a get_act strobe. frame_fnh swaps banks once in-flight reads drain.
//   clk, rst_n    : clock, asynchronous active-low reset
//   cfg_base_addr : first word address of every frame (both banks)
//   fetch_req     : one pulse requests one word
//   frame_fnh     : frame finished, request a bank swap
//   bank_rdy      : per-bank "filled by DMA" flags
//   bank_rel      : one-cycle pulse, current bank released
//   bank_sel      : bank currently being read
//   sram_rd_en    : SRAM read enable
//   sram_addr     : {bank_sel, word pointer}
//   sram_rd_data  : SRAM read data
//   act_data      : returned activation word
//   get_act       : one-cycle strobe, act_data valid
//   pend_ovf      : sticky, a request was dropped on a full pending counter
//   busy          : not idle, or work pending / in flight
// -----------------------------------------------------------------------------
module act_fetch_server
   import act_fetch_server_pkg::*;
#(
   parameter int ACT_WIDTH  = ACT_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int SRAM_LAT   = SRAM_LAT_DEF,
   parameter int PEND_WIDTH = PEND_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic                  fetch_req,
   input  logic                  frame_fnh,
   input  logic [1:0]            bank_rdy,
   output logic                  bank_rel,
   output logic                  bank_sel,
   output logic                  sram_rd_en,
   output logic [ADDR_WIDTH:0]   sram_addr,
   input  logic [ACT_WIDTH-1:0]  sram_rd_data,
   output logic [ACT_WIDTH-1:0]  act_data,
   output logic                  get_act,
   output logic                  pend_ovf,
   output logic                  busy
);

   localparam logic [PEND_WIDTH-1:0] PEND_ONE = {{(PEND_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [PEND_WIDTH-1:0] pend_q, pend_d;
   logic                  bank_sel_q, bank_sel_d;
   logic                  pend_ovf_q, pend_ovf_d;

   logic                  issue;
   logic                  accept;
   logic                  pend_empty;
   logic                  pend_full;
   logic                  bank_ready;
   logic                  inflight_empty;

   assign pend_empty = (pend_q == '0);
   assign pend_full  = &pend_q;
   assign bank_ready = bank_rdy[bank_sel_q];
   assign issue      = (state_q == ST_SERVE) && !pend_empty;

   // ---------------------------------------------------------------------
   // Pending counter. A full counter still accepts a request when a read
   // leaves in the same cycle, since the count does not actually grow.
   // ---------------------------------------------------------------------
   always_comb begin
      accept     = fetch_req && !(pend_full && !issue);
      pend_d     = pend_q;
      pend_ovf_d = pend_ovf_q | (fetch_req & ~accept);
      unique case ({accept, issue})
         2'b10:   pend_d = pend_q + PEND_ONE;
         2'b01:   pend_d = pend_q - PEND_ONE;
         default: pend_d = pend_q;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM, word pointer and bank select.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      bank_sel_d = bank_sel_q;
      bank_rel   = 1'b0;

      if (issue) begin
         ptr_d = ptr_q + PTR_ONE;   // wraps modulo 2^ADDR_WIDTH
      end

      unique case (state_q)
         ST_IDLE: begin
            ptr_d = cfg_base_addr;
            if (frame_fnh) begin
               // Nothing is in flight here, so the swap is immediate.
               bank_rel   = 1'b1;
               bank_sel_d = ~bank_sel_q;
            end else if (!pend_empty || fetch_req) begin
               // Skip the WAIT_BANK cycle when the bank is already filled so
               // a fetch into an idle server issues its read in the next cycle.
               state_d = bank_ready ? ST_SERVE : ST_WAIT_BANK;
            end
         end

         ST_WAIT_BANK: begin
            if (frame_fnh) begin
               state_d = ST_DRAIN;
            end else if (bank_ready) begin
               state_d = ST_SERVE;
            end
         end

         ST_SERVE: begin
            if (frame_fnh) begin
               state_d = ST_DRAIN;
            end else if (pend_empty && inflight_empty && !fetch_req) begin
               // A fetch arriving now is served from SERVE next cycle rather
               // than bouncing through IDLE.
               state_d = ST_IDLE;
            end
         end

         ST_DRAIN: begin
            if (inflight_empty) begin
               bank_rel   = 1'b1;
               bank_sel_d = ~bank_sel_q;
               ptr_d      = cfg_base_addr;
               state_d    = ST_WAIT_BANK;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         pend_q     <= '0;
         bank_sel_q <= 1'b0;
         pend_ovf_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         pend_q     <= pend_d;
         bank_sel_q <= bank_sel_d;
         pend_ovf_q <= pend_ovf_d;
      end
   end

   act_rd_pipe #(
      .ACT_WIDTH (ACT_WIDTH),
      .SRAM_LAT  (SRAM_LAT)
   ) u_rd_pipe (
      .clk            (clk),
      .rst_n          (rst_n),
      .rd_issue       (issue),
      .rd_data        (sram_rd_data),
      .act_data       (act_data),
      .get_act        (get_act),
      .inflight_empty (inflight_empty)
   );

   assign sram_rd_en = issue;
   assign sram_addr  = {bank_sel_q, ptr_q};
   assign bank_sel   = bank_sel_q;
   assign pend_ovf   = pend_ovf_q;
   assign busy       = (state_q != ST_IDLE) || !pend_empty || !inflight_empty;

endmodule

// File: tb/tb_act_fetch_server.sv
// -----------------------------------------------------------------------------
// tb_act_fetch_server
// Directed bench for act_fetch_server with default parameters (SRAM_LAT=2).
// Inputs change 2ns after the rising edge; outputs are sampled on the falling
// edge and logged with the cycle number they occurred in.
// -----------------------------------------------------------------------------
module tb_act_fetch_server;
   import act_fetch_server_pkg::*;

   localparam int AW = ACT_WIDTH_DEF;
   localparam int DW = ADDR_WIDTH_DEF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] cfg_base_addr;
   logic          fetch_req;
   logic          frame_fnh;
   logic [1:0]    bank_rdy;
   logic          bank_rel;
   logic          bank_sel;
   logic          sram_rd_en;
   logic [DW:0]   sram_addr;
   logic [AW-1:0] sram_rd_data;
   logic [AW-1:0] act_data;
   logic          get_act;
   logic          pend_ovf;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int c0;

   int          rd_cyc[$];
   logic [DW:0] rd_addr[$];
   int          ga_cyc[$];
   logic [AW-1:0] ga_data[$];
   int          rel_cyc[$];

   act_fetch_server dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_base_addr (cfg_base_addr),
      .fetch_req     (fetch_req),
      .frame_fnh     (frame_fnh),
      .bank_rdy      (bank_rdy),
      .bank_rel      (bank_rel),
      .bank_sel      (bank_sel),
      .sram_rd_en    (sram_rd_en),
      .sram_addr     (sram_addr),
      .sram_rd_data  (sram_rd_data),
      .act_data      (act_data),
      .get_act       (get_act),
      .pend_ovf      (pend_ovf),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // SRAM content pattern, unique per bank/address.
   function automatic logic [AW-1:0] wordf(input logic [DW:0] a);
      return {16'hC0DE, 3'b000, a, 16'hBEEF, 3'b000, ~a};
   endfunction

   // SRAM model: word appears the cycle after the read and is sampled by the
   // server at the next edge, giving get_act two cycles after sram_rd_en.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sram_rd_en) sram_rd_data <= wordf(sram_addr);
   end

   always @(negedge clk) begin
      if (sram_rd_en) begin
         rd_cyc.push_back(cyc);
         rd_addr.push_back(sram_addr);
         $display("cyc=%0d rd addr=%h", cyc, sram_addr);
      end
      if (get_act) begin
         ga_cyc.push_back(cyc);
         ga_data.push_back(act_data);
         $display("cyc=%0d get_act data=%h", cyc, act_data);
      end
      if (bank_rel) begin
         rel_cyc.push_back(cyc);
         $display("cyc=%0d bank_rel", cyc);
      end
   end

   task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int cyc_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic logic [DW:0] addr_at(input int i);
      return (i < rd_addr.size()) ? rd_addr[i] : '1;
   endfunction

   function automatic logic [AW-1:0] data_at(input int i);
      return (i < ga_data.size()) ? ga_data[i] : '0;
   endfunction

   task automatic clear_logs();
      rd_cyc.delete(); rd_addr.delete(); ga_cyc.delete(); ga_data.delete(); rel_cyc.delete();
   endtask

   // One cycle of stimulus: drive, then advance to 2ns after the next edge.
   task automatic step(input logic fr, input logic ff);
      fetch_req = fr;
      frame_fnh = ff;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   initial begin
      rst_n         = 1'b0;
      cfg_base_addr = 12'h010;
      fetch_req     = 1'b0;
      frame_fnh     = 1'b0;
      bank_rdy      = 2'b00;
      sram_rd_data  = '0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_get_act",  get_act,    0);
      check("rst_rd_en",    sram_rd_en, 0);
      check("rst_bank_sel", bank_sel,   0);
      check("rst_busy",     busy,       0);
      check("rst_pend_ovf", pend_ovf,   0);
      check("rst_act_data", act_data,   0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle(2);

      // ---------------- single fetch ----------------
      bank_rdy = 2'b01;
      clear_logs();
      c0 = cyc;
      step(1'b1, 1'b0);
      idle(6);
      check("single_rd_cnt",  rd_cyc.size(), 1);
      check("single_rd_cyc",  cyc_at(rd_cyc, 0), c0 + 1);
      check("single_rd_addr", addr_at(0), 13'h0010);
      check("single_ga_cyc",  cyc_at(ga_cyc, 0), c0 + 3);
      check("single_ga_data", data_at(0), wordf(13'h0010));
      check("single_busy",    busy, 0);
      check("single_hold",    act_data, wordf(13'h0010));

      // ---------------- back-to-back ----------------
      clear_logs();
      c0 = cyc;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      idle(7);
      check("b2b_rd_cnt", rd_cyc.size(), 4);
      check("b2b_ga_cnt", ga_cyc.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("b2b_rd_cyc%0d", i),  cyc_at(rd_cyc, i), c0 + 1 + i);
         check($sformatf("b2b_rd_addr%0d", i), addr_at(i), 13'h0010 + 13'(i));
         check($sformatf("b2b_ga_cyc%0d", i),  cyc_at(ga_cyc, i), c0 + 3 + i);
         check($sformatf("b2b_ga_data%0d", i), data_at(i), wordf(13'h0010 + 13'(i)));
      end

      // ---------------- bank not ready ----------------
      bank_rdy = 2'b00;
      clear_logs();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      idle(3);
      check("nrdy_rd_cnt", rd_cyc.size(), 0);
      check("nrdy_busy",   busy, 1);
      bank_rdy = 2'b01;
      c0 = cyc;
      idle(8);
      check("nrdy_rd_cnt2", rd_cyc.size(), 3);
      check("nrdy_ga_cnt",  ga_cyc.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("nrdy_rd_cyc%0d", i),  cyc_at(rd_cyc, i), c0 + 1 + i);
         check($sformatf("nrdy_ga_data%0d", i), data_at(i), wordf(13'h0010 + 13'(i)));
      end

      // ---------------- frame swap with reads in flight ----------------
      bank_rdy = 2'b11;
      clear_logs();
      c0 = cyc;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);   // coincides with the 2nd read
      idle(10);
      check("swap_rd_cnt",    rd_cyc.size(), 3);
      check("swap_rd2_cyc",   cyc_at(rd_cyc, 1), c0 + 2);
      check("swap_ga_cnt",    ga_cyc.size(), 3);
      check("swap_ga2_data",  data_at(1), wordf(13'h0011));
      check("swap_rel_cnt",   rel_cyc.size(), 1);
      check("swap_rel_cyc",   cyc_at(rel_cyc, 0), c0 + 5);
      check("swap_rd3_cyc",   cyc_at(rd_cyc, 2), c0 + 7);
      check("swap_rd3_addr",  addr_at(2), 13'h1010);
      check("swap_ga3_data",  data_at(2), wordf(13'h1010));
      check("swap_bank_sel",  bank_sel, 1);

      // ---------------- frame_fnh in IDLE ----------------
      clear_logs();
      c0 = cyc;
      step(1'b0, 1'b1);
      idle(1);
      check("idle_rel_cyc",  cyc_at(rel_cyc, 0), c0);
      check("idle_bank_sel", bank_sel, 0);
      check("idle_busy",     busy, 0);

      // ---------------- pending overflow ----------------
      bank_rdy = 2'b00;
      clear_logs();
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
      check("ovf_before", pend_ovf, 0);
      step(1'b1, 1'b0);
      idle(2);
      check("ovf_set",    pend_ovf, 1);
      check("ovf_no_rd",  rd_cyc.size(), 0);
      bank_rdy = 2'b01;
      idle(15);
      check("ovf_rd_cnt",   rd_cyc.size(), 7);
      check("ovf_ga_cnt",   ga_cyc.size(), 7);
      check("ovf_last_data", data_at(6), wordf(13'h0016));
      check("ovf_sticky",   pend_ovf, 1);

      // ---------------- reset mid-flight ----------------
      bank_rdy = 2'b11;
      step(1'b0, 1'b1);   // move to bank1 so the reset has something to undo
      check("mid_pre_bank", bank_sel, 1);
      clear_logs();
      c0 = cyc;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);   // read issued in this cycle
      rst_n = 1'b0;
      step(1'b0, 1'b0);
      rst_n = 1'b1;
      idle(5);
      check("mid_rd_cnt",   rd_cyc.size(), 1);
      check("mid_ga_cnt",   ga_cyc.size(), 0);
      check("mid_bank_sel", bank_sel, 0);
      check("mid_busy",     busy, 0);
      check("mid_pend_ovf", pend_ovf, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/act_fetch_server.md
Name: act_fetch_server

Overview:
- Responder side of the activation fetch handshake.
- Receives single-cycle fetch pulses from the activation loop controller and reads one activation word per pulse from a ping-pong activation SRAM.
- Returns each word with a single-cycle get-activation strobe. That strobe feeds the controller's next-fetch logic and the PE array.
- Swaps SRAM banks on the controller's frame-finish pulse once all in-flight reads have drained.

Parameters:
- ACT_WIDTH, 64, activation word width.
- ADDR_WIDTH, 12, SRAM word address width per bank.
- SRAM_LAT, 2, fixed SRAM read latency in cycles (1..4).
- PEND_WIDTH, 3, width of the pending-request counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_base_addr  in  ADDR_WIDTH  first word address of every frame, same in both banks.
- fetch_req  in  1  fetch pulse; one pulse requests one word.
- frame_fnh  in  1  frame-finish pulse; requests a bank swap.
- bank_rdy  in  2  per-bank "filled by DMA" flags.
- bank_rel  out  1  one-cycle pulse when the current bank is released.
- bank_sel  out  1  bank currently being read.
- sram_rd_en  out  1  SRAM read enable.
- sram_addr  out  ADDR_WIDTH+1  read address; MSB = bank_sel.
- sram_rd_data  in  ACT_WIDTH  read data, valid SRAM_LAT cycles after sram_rd_en.
- act_data  out  ACT_WIDTH  returned activation word.
- get_act  out  1  one-cycle strobe; act_data valid.
- pend_ovf  out  1  sticky: a request was lost because the pending counter was full.
- busy  out  1  high when state is not IDLE or a request is pending or in flight.

Behaviour:
- Reset values:
  - All outputs 0; bank_sel=0; address pointer=cfg_base_addr, sampled at first leaving IDLE.
  - Pending counter, in-flight shift register and state all 0 / IDLE.
- Pending counter:
  - fetch_req increments it; an issued read decrements it.
  - Simultaneous increment and decrement leaves it unchanged.
  - At 2^PEND_WIDTH-1 with an incoming fetch_req: request dropped, pend_ovf set. pend_ovf clears only on reset.
- FSM states: IDLE, WAIT_BANK, SERVE, DRAIN.
- IDLE:
  - pending>0 or fetch_req -> WAIT_BANK.
  - Latches pointer=cfg_base_addr.
- WAIT_BANK:
  - bank_rdy[bank_sel]=1 -> SERVE.
  - No reads issued.
- SERVE:
  - Issues one read per cycle while pending>0: sram_rd_en=1, sram_addr={bank_sel,pointer}, pointer+1.
  - Pointer wraps modulo 2^ADDR_WIDTH, no flag.
  - Read latency: a fetch_req seen in cycle t with an empty pending counter issues its read in cycle t+1. get_act fires in cycle t+1+SRAM_LAT.
- In-flight tracking:
  - SRAM_LAT-deep valid shift register. Output of the last stage drives get_act.
  - act_data is registered from sram_rd_data in the same cycle get_act is driven and holds its value until the next get_act.
- Frame swap:
  - frame_fnh in SERVE or WAIT_BANK -> DRAIN. Reads stop immediately.
  - A fetch_req coincident with frame_fnh belongs to the new frame and stays pending.
- DRAIN:
  - Waits until the in-flight shift register is empty.
  - Then, in one cycle: bank_rel pulses, bank_sel toggles, pointer=cfg_base_addr, go to WAIT_BANK.
- frame_fnh in IDLE: swap immediately (bank_rel pulse, toggle), stay in IDLE.
- frame_fnh in DRAIN: ignored.
- SERVE with pending=0 and nothing in flight -> IDLE; bank_sel is kept.
- bank_rdy deasserting during SERVE is a protocol error and is not checked.
- Asynchronous reset mid-operation: in-flight reads are discarded; no get_act is issued for them.

Decomposition:
- Shared package/include holds:
  - State encoding, 2 bits.
  - Default widths ACT_WIDTH/ADDR_WIDTH, consistent with the loop-controller width macros.
  - The SRAM_LAT constant used by the SRAM wrapper.
- One natural sub-module, act_rd_pipe: the SRAM_LAT-stage valid shift register plus the act_data capture register. It exposes an in-flight-empty flag.
- FSM, pointer and pending counter stay in the top level.

Test Plan:
- Single fetch, bank0 ready, base=0x010, SRAM_LAT=2:
  - fetch_req at cycle 5 -> sram_rd_en at cycle 6 with addr 0x010.
  - get_act at cycle 8 with the word at bank0:0x010.
- Back-to-back: fetch_req held 4 cycles -> reads 0x010..0x013 issued on consecutive cycles; four get_act strobes in consecutive cycles with data in order.
- Bank not ready: bank_rdy=0, 3 fetches -> no sram_rd_en, pending=3.
  - Raise bank_rdy[0] -> 3 consecutive reads, 3 get_act strobes.
- Frame swap with reads in flight:
  - frame_fnh and fetch_req in the same cycle as the 2nd read -> that read still returns.
  - bank_rel pulses after the in-flight register empties; bank_sel=1.
  - Pending fetch served from bank1:base.
- Overflow: PEND_WIDTH=3, bank not ready, 8 fetches -> pending=7, pend_ovf=1.
  - After bank_rdy, exactly 7 get_act strobes.
- Reset mid-flight: assert rst_n low 1 cycle after a read issue -> get_act never fires; bank_sel=0; busy=0.
